// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared widths, state encoding and saturation limits for the MAC datapath
package mult_pkg;
    localparam int IN_W  = 64;
    localparam int ACC_W = 80;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } mac_state_e;

    // Limits are built wide and truncated by the caller to its own accumulator width.
    function automatic logic [127:0] sat_max(input int w);
        return (128'd1 << (w - 1)) - 128'd1;
    endfunction

    function automatic logic [127:0] sat_min(input int w);
        return ~sat_max(w);
    endfunction
endpackage

// File: rtl/sat_adder.sv
// rtl/sat_adder.sv - signed saturating add of a sign-extended product into the accumulator
module sat_adder #(
    parameter int IN_W  = mult_pkg::IN_W,
    parameter int ACC_W = mult_pkg::ACC_W
) (
    input  logic [ACC_W-1:0] a,
    input  logic [IN_W-1:0]  b,
    output logic [ACC_W-1:0] sum,
    output logic             overflow
);
    import mult_pkg::*;

    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W));

    logic [ACC_W:0] wide;
    logic           pos_ovf;
    logic           neg_ovf;

    // One guard bit: the top two bits disagree exactly when the true sum leaves ACC_W range.
    always_comb begin
        wide     = {a[ACC_W-1], a} + {{(ACC_W + 1 - IN_W){b[IN_W-1]}}, b};
        pos_ovf  = (wide[ACC_W:ACC_W-1] == 2'b01);
        neg_ovf  = (wide[ACC_W:ACC_W-1] == 2'b10);
        overflow = pos_ovf | neg_ovf;
        if (pos_ovf) begin
            sum = SAT_MAX;
        end else if (neg_ovf) begin
            sum = SAT_MIN;
        end else begin
            sum = wide[ACC_W-1:0];
        end
    end
endmodule

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - sums bursts of signed products and presents the total on a valid/ready port
module mac_accumulator #(
    parameter int IN_W  = mult_pkg::IN_W,
    parameter int ACC_W = mult_pkg::ACC_W,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [IN_W-1:0]  i_product,
    input  logic             i_last,
    input  logic             i_clear,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [ACC_W-1:0] o_acc,
    output logic [CNT_W-1:0] o_count,
    output logic             o_overflow
);
    import mult_pkg::*;

    mac_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] res_acc_q, res_acc_d;
    logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
    logic             res_ovf_q, res_ovf_d;

    logic             accept;
    logic [ACC_W-1:0] base_acc;
    logic [CNT_W-1:0] base_cnt;
    logic             base_ovf;
    logic [ACC_W-1:0] sum;
    logic             add_ovf;
    logic [CNT_W-1:0] inc_cnt;

    assign accept   = i_valid && (state_q == ACCUM);
    // A clear coinciding with a beat wipes the old sum first, so the beat starts a fresh burst.
    assign base_acc = i_clear ? '0 : acc_q;
    assign base_cnt = i_clear ? '0 : cnt_q;
    assign base_ovf = i_clear ? 1'b0 : ovf_q;
    assign inc_cnt  = (&base_cnt) ? base_cnt : base_cnt + CNT_W'(1);

    sat_adder #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_sat_adder (
        .a        (base_acc),
        .b        (i_product),
        .sum      (sum),
        .overflow (add_ovf)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        res_acc_d = res_acc_q;
        res_cnt_d = res_cnt_q;
        res_ovf_d = res_ovf_q;
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    acc_d = sum;
                    cnt_d = inc_cnt;
                    ovf_d = base_ovf | add_ovf;
                    if (i_last) begin
                        res_acc_d = sum;
                        res_cnt_d = inc_cnt;
                        res_ovf_d = base_ovf | add_ovf;
                        state_d   = HOLD;
                    end
                end else if (i_clear) begin
                    acc_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end
            end
            HOLD: begin
                if (i_ready) begin
                    state_d   = ACCUM;
                    acc_d     = '0;
                    cnt_d     = '0;
                    ovf_d     = 1'b0;
                    res_ovf_d = 1'b0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            res_acc_q <= '0;
            res_cnt_q <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            res_acc_q <= res_acc_d;
            res_cnt_q <= res_cnt_d;
            res_ovf_q <= res_ovf_d;
        end
    end

    assign o_ready    = (state_q == ACCUM);
    assign o_valid    = (state_q == HOLD);
    assign o_acc      = res_acc_q;
    assign o_count    = res_cnt_q;
    assign o_overflow = res_ovf_q;
endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - scoreboard bench for mac_accumulator with a clamped-arithmetic reference model
module tb_mac_accumulator;
    localparam int TB_IN_W  = 64;
    localparam int TB_ACC_W = 72;
    localparam int TB_CNT_W = 8;

    logic                clk;
    logic                rst_n;
    logic                i_valid;
    logic                o_ready;
    logic [TB_IN_W-1:0]  i_product;
    logic                i_last;
    logic                i_clear;
    logic                o_valid;
    logic                i_ready;
    logic [TB_ACC_W-1:0] o_acc;
    logic [TB_CNT_W-1:0] o_count;
    logic                o_overflow;

    mac_accumulator #(
        .IN_W  (TB_IN_W),
        .ACC_W (TB_ACC_W),
        .CNT_W (TB_CNT_W)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_product  (i_product),
        .i_last     (i_last),
        .i_clear    (i_clear),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_acc      (o_acc),
        .o_count    (o_count),
        .o_overflow (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [TB_ACC_W-1:0] acc;
        int                  cnt;
        bit                  ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic signed [127:0] m_sum;
    int                  m_cnt;
    bit                  m_ovf;
    logic signed [127:0] acc_max;
    logic signed [127:0] acc_min;
    int                  cnt_max;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, expv);
        end
    endtask

    task automatic model_clear();
        m_sum = '0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    // Reference: exact integer sum clamped to the signed accumulator range after every beat.
    task automatic model_beat(input logic [63:0] p, input bit clr, input bit last);
        logic signed [63:0]  ps;
        logic signed [127:0] pw;
        logic signed [127:0] s;
        exp_t                e;
        if (clr) model_clear();
        ps = p;
        pw = ps;
        s  = m_sum + pw;
        if (s > acc_max) begin
            m_sum = acc_max;
            m_ovf = 1'b1;
        end else if (s < acc_min) begin
            m_sum = acc_min;
            m_ovf = 1'b1;
        end else begin
            m_sum = s;
        end
        if (m_cnt < cnt_max) m_cnt = m_cnt + 1;
        if (last) begin
            e.acc = m_sum[TB_ACC_W-1:0];
            e.cnt = m_cnt;
            e.ovf = m_ovf;
            exp_q.push_back(e);
            model_clear();
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send_beat(input logic [63:0] p, input bit last, input bit clr, output int waited);
        waited    = 0;
        i_valid   = 1'b1;
        i_product = p;
        i_last    = last;
        i_clear   = clr;
        @(negedge clk);
        while (!o_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!o_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got o_ready=0 for %0d cycles, expected 1", waited);
            i_valid = 1'b0;
            i_last  = 1'b0;
            i_clear = 1'b0;
            @(posedge clk);
            #1;
        end else begin
            if (last) check("valid_before_last", o_valid, 0);
            model_beat(p, clr, last);
            @(posedge clk);
            #1;
            i_valid = 1'b0;
            i_last  = 1'b0;
            i_clear = 1'b0;
            if (last) check("valid_latency", o_valid, 1);
        end
    endtask

    task automatic beat(input logic [63:0] p, input bit last, input bit clr);
        int w;
        send_beat(p, last, clr, w);
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_clear();
        i_valid = 1'b0;
        i_clear = 1'b1;
        @(negedge clk);
        check("clear_in_accum", o_ready, 1);
        model_clear();
        @(posedge clk);
        #1;
        i_clear = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, o_ready, 1);
        check({tag, "_valid"}, o_valid, 0);
        check({tag, "_acc"}, o_acc, 0);
        check({tag, "_count"}, o_count, 0);
        check({tag, "_ovf"}, o_overflow, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got o_acc %0h, expected no result", o_acc);
            end else begin
                e = exp_q.pop_front();
                check("result_acc", o_acc, e.acc);
                check("result_count", o_count, e.cnt);
                check("result_ovf", o_overflow, e.ovf);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int nb;
        logic [63:0] rp;
        acc_max = 128'sd1;
        acc_max = (acc_max << (TB_ACC_W - 1)) - 128'sd1;
        acc_min = -acc_max - 128'sd1;
        cnt_max = (1 << TB_CNT_W) - 1;
        model_clear();

        rst_n     = 1'b0;
        i_valid   = 1'b0;
        i_product = '0;
        i_last    = 1'b0;
        i_clear   = 1'b0;
        i_ready   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;

        beat(64'd156, 1'b1, 1'b0);
        beat(64'd144, 1'b1, 1'b0);
        beat(-64'sd144, 1'b1, 1'b0);

        beat(64'd156, 1'b0, 1'b0);
        idle(2);
        beat(64'd144, 1'b0, 1'b0);
        idle(1);
        beat(-64'sd144, 1'b0, 1'b0);
        idle(3);
        beat(64'd5, 1'b1, 1'b0);

        for (int b = 0; b < 8; b++) begin
            nb = $urandom_range(1, 8);
            for (int k = 0; k < nb; k++) begin
                rp = {$urandom, $urandom};
                if ($urandom_range(0, 3) == 0) rp = {{40{rp[23]}}, rp[23:0]};
                beat(rp, k == nb - 1, (k == 0) && ($urandom_range(0, 4) == 0));
                idle($urandom_range(0, 2));
            end
        end

        i_ready = 1'b0;
        beat(64'd11, 1'b1, 1'b0);
        i_valid   = 1'b1;
        i_product = 64'd777;
        i_last    = 1'b1;
        i_clear   = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("bp_ready", o_ready, 0);
            check("bp_acc_stable", o_acc, 11);
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_clear = 1'b0;
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("drain_valid_drop", o_valid, 0);
        check("drain_ready_rise", o_ready, 1);
        @(posedge clk);
        #1;
        send_beat(64'd5, 1'b1, 1'b0, w);
        check("accept_after_drain", w, 0);

        for (int k = 0; k < 257; k++) beat(64'h7FFF_FFFF_FFFF_FFFF, k == 256, 1'b0);
        beat(64'd1, 1'b0, 1'b0);
        beat(64'd2, 1'b1, 1'b0);
        for (int k = 0; k < 257; k++) beat(64'h8000_0000_0000_0000, k == 256, 1'b0);

        beat(64'd100, 1'b0, 1'b0);
        beat(64'd200, 1'b0, 1'b0);
        do_clear();
        beat(64'd7, 1'b1, 1'b0);
        beat(64'd50, 1'b0, 1'b0);
        beat(64'd9, 1'b1, 1'b1);

        beat(64'd1, 1'b0, 1'b0);
        beat(64'd2, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_mid");
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        i_ready = 1'b0;
        beat(64'd42, 1'b1, 1'b0);
        check("hold_before_reset", o_acc, 42);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_hold");
        exp_q.delete();
        model_clear();
        @(negedge clk);
        rst_n   = 1'b1;
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        beat(64'd3, 1'b1, 1'b0);

        idle(4);
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
